// File: rtl/sm_rule_filter_avlstrm.sv
// Rule filter on the checked packet path: pairs each metadata record with one packet,
// forwards packets that matched at least one rule and drains the rest, with statistics.
module sm_rule_filter_avlstrm #(
  parameter int PKT_W    = 512,
  parameter int EMPTY_W  = 6,
  parameter int META_W   = 128,
  parameter int RCNT_LSB = 0,
  parameter int RCNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [PKT_W-1:0]   in_pkt_data,
  input  logic               in_pkt_valid,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  output logic               in_pkt_ready,
  input  logic [META_W-1:0]  in_meta_data,
  input  logic               in_meta_valid,
  output logic               in_meta_ready,
  output logic [PKT_W-1:0]   out_pkt_data,
  output logic               out_pkt_sop,
  output logic               out_pkt_eop,
  output logic [EMPTY_W-1:0] out_pkt_empty,
  output logic               out_pkt_valid,
  input  logic               out_pkt_ready,
  output logic [META_W-1:0]  out_meta_data,
  output logic               out_meta_valid,
  input  logic               out_meta_ready,
  output logic [31:0]        stats_fwd_pkt,
  output logic [31:0]        stats_drop_pkt,
  output logic [31:0]        stats_err
);

  typedef enum logic [1:0] {IDLE, META_OUT, FWD, DROP} state_t;

  state_t              state_q, state_d;
  logic [META_W-1:0]   meta_q;
  logic                meta_rdy_q, meta_vld_q, first_q;
  logic [31:0]         fwd_q, drop_q, err_q;
  logic                in_pkt_st, pkt_hs, frame_err;

  assign in_pkt_st = (state_q == FWD) || (state_q == DROP);
  assign pkt_hs    = in_pkt_valid && in_pkt_ready;
  // First beat must carry sop, later beats must not; one error per beat at most.
  assign frame_err = pkt_hs && in_pkt_st && (first_q ? !in_pkt_sop : in_pkt_sop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_meta_valid && meta_rdy_q)
                  state_d = (in_meta_data[RCNT_LSB +: RCNT_W] != '0) ? META_OUT : DROP;
      META_OUT: if (out_meta_ready) state_d = FWD;
      FWD,
      DROP:     if (pkt_hs && in_pkt_eop) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Meta-side handshake signals are registered from the next state so both read 0 in reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      meta_q     <= '0;
      meta_rdy_q <= 1'b0;
      meta_vld_q <= 1'b0;
      first_q    <= 1'b1;
      fwd_q      <= '0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      meta_rdy_q <= (state_d == IDLE);
      meta_vld_q <= (state_d == META_OUT);
      if (state_q == IDLE && in_meta_valid && meta_rdy_q) meta_q <= in_meta_data;
      if (!in_pkt_st)  first_q <= 1'b1;
      else if (pkt_hs) first_q <= 1'b0;
      if (state_q == FWD && pkt_hs && in_pkt_eop)  fwd_q  <= fwd_q + 32'd1;
      if (state_q == DROP && pkt_hs && in_pkt_eop) drop_q <= drop_q + 32'd1;
      if (frame_err) err_q <= err_q + 32'd1;
    end
  end

  assign in_meta_ready  = meta_rdy_q;
  assign out_meta_valid = meta_vld_q;
  assign out_meta_data  = meta_q;

  // FWD is a zero-latency pass-through; DROP sinks every beat.
  assign in_pkt_ready  = (state_q == DROP) || ((state_q == FWD) && out_pkt_ready);
  assign out_pkt_valid = (state_q == FWD) && in_pkt_valid;
  assign out_pkt_data  = in_pkt_data;
  assign out_pkt_sop   = in_pkt_sop;
  assign out_pkt_eop   = in_pkt_eop;
  assign out_pkt_empty = in_pkt_empty;

  assign stats_fwd_pkt  = fwd_q;
  assign stats_drop_pkt = drop_q;
  assign stats_err      = err_q;

endmodule

// File: tb/tb_sm_rule_filter_avlstrm.sv
// Bench for sm_rule_filter_avlstrm: packet table plus hand sequences, scoreboard on outputs.
module tb_sm_rule_filter_avlstrm;

  logic         Clk, Rst_n;
  logic [511:0] in_pkt_data, out_pkt_data;
  logic         in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_ready;
  logic [5:0]   in_pkt_empty, out_pkt_empty;
  logic [127:0] in_meta_data, out_meta_data;
  logic         in_meta_valid, in_meta_ready;
  logic         out_pkt_sop, out_pkt_eop, out_pkt_valid, out_pkt_ready;
  logic         out_meta_valid, out_meta_ready;
  logic [31:0]  stats_fwd_pkt, stats_drop_pkt, stats_err;

  sm_rule_filter_avlstrm dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .stats_fwd_pkt(stats_fwd_pkt), .stats_drop_pkt(stats_drop_pkt), .stats_err(stats_err)
  );

  typedef struct packed {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   emp;
  } beat_t;

  typedef struct {
    logic [15:0] rcnt;
    int          nb;
    bit          bad_sop;
    int          mid_sop;
    logic [5:0]  emp;
    int          e_fwd, e_drop, e_err;
  } vec_t;

  beat_t        bq[$];
  logic [127:0] mq[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, pop_cyc = 0, beats_out = 0;
  bit  abort = 0, pkt_rand = 0, done = 0, mv_prev = 0, got = 0;
  logic [127:0] last_meta;

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial forever begin
    @(posedge Clk);
    cyc++;
    #1 out_pkt_ready = pkt_rand ? 1'($urandom) : 1'b1;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor samples one time unit before each rising edge.
  initial forever begin
    @(negedge Clk);
    #4;
    if (Rst_n) begin
      if (out_meta_valid && !mv_prev) chk("meta_latency", 512'(cyc), 512'(pop_cyc + 1));
      mv_prev = out_meta_valid;
      if (out_meta_valid && out_meta_ready) begin
        if (mq.size() == 0) chk("meta_unexpected", 512'(1), 512'(0));
        else chk("meta_data", 512'(out_meta_data), 512'(mq.pop_front()));
      end
      if (out_pkt_valid && out_pkt_ready) begin
        beat_t b;
        beats_out++;
        if (bq.size() == 0) chk("beat_unexpected", 512'(1), 512'(0));
        else begin
          b = bq.pop_front();
          chk("beat_data", out_pkt_data, b.d);
          chk("beat_ctl", 512'({out_pkt_sop, out_pkt_eop, out_pkt_empty}), 512'({b.sop, b.eop, b.emp}));
        end
      end
    end else mv_prev = 0;
  end

  task automatic send_pkt(input logic [15:0] rcnt, input int nb, input bit bad_sop,
                          input int mid_sop, input logic [5:0] emp);
    beat_t bs[8];
    logic [127:0] m;
    bit hs;
    m = {$urandom, $urandom, $urandom, $urandom};
    m[15:0] = rcnt;
    last_meta = m;
    for (int i = 0; i < nb; i++) begin
      bs[i].d   = {16{$urandom}};
      bs[i].sop = (i == 0) ? !bad_sop : (i == mid_sop);
      bs[i].eop = (i == nb - 1);
      bs[i].emp = (i == nb - 1) ? emp : 6'd0;
      if (rcnt != 0) bq.push_back(bs[i]);
    end
    if (rcnt != 0) mq.push_back(m);
    @(negedge Clk);
    in_meta_valid = 1;
    in_meta_data  = m;
    hs = 0;
    for (int t = 0; t < 50 && !hs && !abort; t++) begin
      #4;
      hs = in_meta_ready;
      if (hs) pop_cyc = cyc;
      @(posedge Clk);
      if (!hs) @(negedge Clk);
    end
    if (!hs && !abort) chk("meta_pop_timeout", 512'(0), 512'(1));
    if (hs) @(negedge Clk);
    in_meta_valid = 0;
    if (!hs || abort) return;
    for (int i = 0; i < nb && !abort; i++) begin
      if (i > 0) @(negedge Clk);
      in_pkt_valid = 1;
      {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty} = bs[i];
      hs = 0;
      for (int t = 0; t < 200 && !hs && !abort; t++) begin
        #4;
        hs = in_pkt_ready;
        if (t == 0 && rcnt == 0 && !abort) chk("drop_ready", 512'(in_pkt_ready), 512'(1));
        @(posedge Clk);
        if (!hs) @(negedge Clk);
      end
      if (!hs && !abort) chk("beat_timeout", 512'(0), 512'(1));
    end
    @(negedge Clk);
    in_pkt_valid = 0;
  endtask

  task automatic do_reset();
    Rst_n = 0;
    mq.delete();
    bq.delete();
    beats_out = 0;
    repeat (2) @(negedge Clk);
    Rst_n = 1;
  endtask

  task automatic chk_stats(input string nm, input int f, input int d, input int e);
    repeat (2) @(negedge Clk);
    #4;
    chk({nm, "_fwd"},  512'(stats_fwd_pkt),  512'(f));
    chk({nm, "_drop"}, 512'(stats_drop_pkt), 512'(d));
    chk({nm, "_err"},  512'(stats_err),      512'(e));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'd3,      2, 0, 0, 6'd5, 1, 0, 0};
    vecs[1] = '{16'd0,      3, 0, 0, 6'd2, 0, 1, 0};
    vecs[2] = '{16'd1,      2, 1, 0, 6'd0, 1, 0, 1};
    vecs[3] = '{16'h8000,   1, 0, 0, 6'd63, 1, 0, 0};
    vecs[4] = '{16'd0,      2, 1, 1, 6'd1, 0, 1, 2};
    vecs[5] = '{16'd5,      3, 0, 1, 6'd7, 1, 0, 1};

    in_pkt_valid = 0; in_meta_valid = 0; in_pkt_data = '0; in_pkt_sop = 0;
    in_pkt_eop = 0; in_pkt_empty = '0; in_meta_data = '0; out_meta_ready = 1;
    Rst_n = 1;
    #1 Rst_n = 0;
    #1;
    chk("rst_in_meta_ready", 512'(in_meta_ready), 512'(0));
    chk("rst_in_pkt_ready",  512'(in_pkt_ready),  512'(0));
    chk("rst_out_valids",    512'({out_pkt_valid, out_meta_valid}), 512'(0));
    chk("rst_stats", 512'({stats_fwd_pkt, stats_drop_pkt, stats_err}), 512'(0));
    chk("rst_meta_reg", 512'(out_meta_data), 512'(0));

    foreach (vecs[v]) begin
      do_reset();
      send_pkt(vecs[v].rcnt, vecs[v].nb, vecs[v].bad_sop, vecs[v].mid_sop, vecs[v].emp);
      chk_stats($sformatf("vec%0d", v), vecs[v].e_fwd, vecs[v].e_drop, vecs[v].e_err);
      chk($sformatf("vec%0d_beats", v), 512'(beats_out), 512'(vecs[v].rcnt != 0 ? vecs[v].nb : 0));
      chk($sformatf("vec%0d_sb_left", v), 512'(bq.size() + mq.size()), 512'(0));
    end

    // Metadata back-pressure: record held for 6 cycles, no packet beats accepted meanwhile.
    do_reset();
    out_meta_ready = 0;
    done = 0;
    fork begin send_pkt(16'd1, 2, 0, 0, 6'd3); done = 1; end join_none
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin @(negedge Clk); #4; got = out_meta_valid; end
    chk("bp_meta_seen", 512'(got), 512'(1));
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        @(posedge Clk);
        if (k == 6) #1 out_meta_ready = 1;
        @(negedge Clk); #4;
      end
      chk($sformatf("bp_valid_c%0d", k), 512'(out_meta_valid), 512'(1));
      chk($sformatf("bp_data_c%0d", k), 512'(out_meta_data), 512'(last_meta));
      chk($sformatf("bp_pkt_ready_c%0d", k), 512'(in_pkt_ready), 512'(0));
    end
    for (int t = 0; t < 100 && !done; t++) @(negedge Clk);
    chk("bp_done", 512'(done), 512'(1));
    chk_stats("bp", 1, 0, 0);

    // Eight single-beat packets, alternating forward/drop, random downstream ready.
    do_reset();
    pkt_rand = 1;
    for (int i = 0; i < 8; i++) send_pkt((i % 2 == 0) ? 16'd2 : 16'd0, 1, 0, 0, 6'(i));
    pkt_rand = 0;
    chk_stats("b2b", 4, 4, 0);
    chk("b2b_beats", 512'(beats_out), 512'(4));

    // Reset in the middle of a forwarded 4-beat packet, then a normal packet.
    beats_out = 0;
    done = 0;
    fork begin send_pkt(16'd1, 4, 0, 0, 6'd9); done = 1; end join_none
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin @(negedge Clk); #4; got = (beats_out >= 1); end
    chk("mid_first_beat", 512'(got), 512'(1));
    @(negedge Clk);
    #1 abort = 1;
    Rst_n = 0;
    #1;
    chk("mid_rst_readies", 512'({in_pkt_ready, in_meta_ready}), 512'(0));
    chk("mid_rst_valids",  512'({out_pkt_valid, out_meta_valid}), 512'(0));
    chk("mid_rst_stats", 512'({stats_fwd_pkt, stats_drop_pkt, stats_err}), 512'(0));
    for (int t = 0; t < 20 && !done; t++) @(negedge Clk);
    chk("mid_abort_done", 512'(done), 512'(1));
    abort = 0;
    do_reset();
    send_pkt(16'd2, 3, 0, 0, 6'd4);
    chk_stats("post_rst", 1, 0, 0);
    chk("post_rst_beats", 512'(beats_out), 512'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
